// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers, used by both the write-side full generator and
// the read-side empty generator.
//   fifo_depth(ptr_width) : entries addressed by a pointer that carries a wrap bit
//   bin2gray / gray2bin   : width-agnostic code conversion on a GRAY_MAX_W
//                           container; callers zero-extend in and truncate out.
//                           Zero extension commutes with both conversions, so
//                           a single pair of functions serves every pointer width.
package fifo_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_vec_t;

  // One wrap bit on top of the address bits.
  function automatic int unsigned fifo_depth(input int unsigned ptr_width);
    return 32'(1) << (ptr_width - 32'd1);
  endfunction

  function automatic gray_vec_t bin2gray(input gray_vec_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of its own Gray bit and every Gray bit above it.
  function automatic gray_vec_t gray2bin(input gray_vec_t g);
    gray_vec_t b;
    b = g;
    for (int unsigned s = 1; s < GRAY_MAX_W; s++) begin
      b = b ^ (g >> s);
    end
    return b;
  endfunction

endpackage : fifo_pkg

// File: rtl/wr_full_gen_if.sv
// Write-side status bus between the write pointer stage and wr_full_gen.
//   inc         : qualified write enable from the pointer stage
//   ptr         : current binary write pointer
//   next_ptr    : ptr + 1 from the pointer stage
//   rd_gray     : Gray read pointer, asynchronous to the write clock
//   wr_gray     : registered Gray write pointer to the read domain
//   full        : registered full flag (fed back to the pointer stage)
//   almost_full : registered level >= threshold
//   level       : registered write-side occupancy
// master = pointer stage / environment, slave = wr_full_gen.
interface wr_full_gen_if #(
  parameter int unsigned PTR_WIDTH = 5
);

  logic                 inc;
  logic [PTR_WIDTH-1:0] ptr;
  logic [PTR_WIDTH-1:0] next_ptr;
  logic [PTR_WIDTH-1:0] rd_gray;
  logic [PTR_WIDTH-1:0] wr_gray;
  logic                 full;
  logic                 almost_full;
  logic [PTR_WIDTH-1:0] level;

  modport master (
    output inc, ptr, next_ptr, rd_gray,
    input  wr_gray, full, almost_full, level
  );

  modport slave (
    input  inc, ptr, next_ptr, rd_gray,
    output wr_gray, full, almost_full, level
  );

endinterface : wr_full_gen_if

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
// Only the second stage is exported; the first stage may go metastable.
//   clk : destination-domain clock
//   rst : synchronous active-high reset, clears both stages
//   d_i : asynchronous input vector (must change one bit at a time)
//   q_o : synchronized output, two edges behind d_i
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q1_q;
  logic [WIDTH-1:0] q2_q;

  // Synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      q1_q <= '0;
      q2_q <= '0;
    end else begin
      q1_q <= d_i;
      q2_q <= q1_q;
    end
  end

  assign q_o = q2_q;

endmodule : sync_2ff

// File: rtl/wr_full_gen.sv
// Write-side status generator for the asynchronous FIFO.
// Converts the advancing write pointer to Gray for the read domain, brings the
// read domain's Gray pointer across through a two-flop synchronizer, and
// produces registered full / almost_full / level. full is pessimistic: it can
// stay high a few edges after the reader frees a slot, but it is never late to
// assert, so a write into a full FIFO cannot happen.
//   clk : write-domain clock
//   rst : synchronous active-high reset, clears every flop including the
//         synchronizer
//   bus : wr_full_gen_if.slave (inc, ptr, next_ptr, rd_gray in;
//         wr_gray, full, almost_full, level out)
// Parameters:
//   PTR_WIDTH : pointer width including the wrap bit (>= 3), depth 2**(PTR_WIDTH-1)
//   AF_THRESH : almost_full when level >= AF_THRESH, legal 1..depth
module wr_full_gen
  import fifo_pkg::*;
#(
  parameter int unsigned PTR_WIDTH = 5,
  parameter int unsigned AF_THRESH = 12
) (
  input  logic         clk,
  input  logic         rst,
  wr_full_gen_if.slave bus
);

  // AF_THRESH <= depth < 2**PTR_WIDTH, so it always fits in the level width.
  localparam logic [PTR_WIDTH-1:0] AF_LEVEL = PTR_WIDTH'(AF_THRESH);

  logic [PTR_WIDTH-1:0] wr_gray_q, wr_gray_d;
  logic [PTR_WIDTH-1:0] level_q,   level_d;
  logic                 full_q,    full_d;
  logic                 afull_q,   afull_d;

  logic [PTR_WIDTH-1:0] rq2;
  logic [PTR_WIDTH-1:0] rq2_full_pat;
  logic [PTR_WIDTH-1:0] rbin;
  logic [PTR_WIDTH-1:0] bin_next;

  // Read pointer crossing into the write domain.
  sync_2ff #(
    .WIDTH (PTR_WIDTH)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.rd_gray),
    .q_o (rq2)
  );

  // Full in Gray space: writer is one lap ahead, i.e. the top two bits are
  // inverted and the rest match.
  assign rq2_full_pat = {~rq2[PTR_WIDTH-1 -: 2], rq2[PTR_WIDTH-3:0]};

  // Next-state: pointer advance (blocked while full) and status from it.
  always_comb begin
    bin_next  = bus.ptr;
    rbin      = '0;
    wr_gray_d = wr_gray_q;
    level_d   = level_q;
    full_d    = full_q;
    afull_d   = afull_q;

    if (bus.inc && !full_q) begin
      bin_next = bus.next_ptr;
    end

    rbin      = PTR_WIDTH'(gray2bin(GRAY_MAX_W'(rq2)));
    wr_gray_d = PTR_WIDTH'(bin2gray(GRAY_MAX_W'(bin_next)));
    // Modulo subtraction keeps the occupancy right across pointer roll-over.
    level_d   = bin_next - rbin;
    full_d    = (wr_gray_d == rq2_full_pat);
    afull_d   = (level_d >= AF_LEVEL);
  end

  // Status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_gray_q <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
    end else begin
      wr_gray_q <= wr_gray_d;
      level_q   <= level_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
    end
  end

  assign bus.wr_gray     = wr_gray_q;
  assign bus.level       = level_q;
  assign bus.full        = full_q;
  assign bus.almost_full = afull_q;

endmodule : wr_full_gen

// File: tb/tb_wr_full_gen.sv
// Directed bench for wr_full_gen (PTR_WIDTH=5, depth 16, AF_THRESH=12).
module tb_wr_full_gen;

  localparam int unsigned PW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  wr_full_gen_if #(.PTR_WIDTH(PW)) bus ();

  wr_full_gen #(
    .PTR_WIDTH (PW),
    .AF_THRESH (12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic inc, input logic [PW-1:0] p);
    bus.inc      = inc;
    bus.ptr      = p;
    bus.next_ptr = p + 5'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.inc      = 1'($urandom);
      bus.ptr      = 5'($urandom);
      bus.next_ptr = 5'($urandom);
      bus.rd_gray  = 5'($urandom);
      tick();
    end
    n_checks++; if (bus.wr_gray !== 5'd0) begin n_fail++; $display("FAIL reset_wr_gray got=%b exp=%b", bus.wr_gray, 5'd0); end
    n_checks++; if (bus.level !== 5'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
    n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    n_checks++; if (bus.almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af got=%b exp=0", bus.almost_full); end
    n_checks++; if (dut.u_sync.q_o !== 5'd0) begin n_fail++; $display("FAIL reset_rq2 got=%b exp=0", dut.u_sync.q_o); end
    rst = 1'b0;
    bus.rd_gray = 5'd0;
    drive(1'b0, 5'd0);
    tick();
    n_checks++; if (bus.level !== 5'd0) begin n_fail++; $display("FAIL idle_level got=%0d exp=0", bus.level); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 5'(i));
      tick();
      n_checks++; if (bus.level !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, bus.level, i + 1); end
      n_checks++; if (bus.almost_full !== (i + 1 >= 12)) begin n_fail++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, bus.almost_full, (i + 1 >= 12)); end
      n_checks++; if (bus.full !== (i == 15)) begin n_fail++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, bus.full, (i == 15)); end
    end
    n_checks++; if (bus.wr_gray !== 5'b11000) begin n_fail++; $display("FAIL fill_wr_gray got=%b exp=11000", bus.wr_gray); end
  endtask

  task automatic test_blocked();
    drive(1'b1, 5'd16);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (bus.wr_gray !== 5'b11000) begin n_fail++; $display("FAIL blocked_wr_gray[%0d] got=%b exp=11000", i, bus.wr_gray); end
      n_checks++; if (bus.level !== 5'd16) begin n_fail++; $display("FAIL blocked_level[%0d] got=%0d exp=16", i, bus.level); end
      n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL blocked_full[%0d] got=%b exp=1", i, bus.full); end
    end
  endtask

  task automatic test_release();
    drive(1'b0, 5'd16);
    bus.rd_gray = 5'b00001;
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_checks++; if (bus.full !== (e < 3)) begin n_fail++; $display("FAIL release_full[edge %0d] got=%b exp=%b", e, bus.full, (e < 3)); end
      n_checks++; if (bus.level !== ((e < 3) ? 5'd16 : 5'd15)) begin n_fail++; $display("FAIL release_level[edge %0d] got=%0d exp=%0d", e, bus.level, (e < 3) ? 16 : 15); end
      n_checks++; if (bus.almost_full !== 1'b1) begin n_fail++; $display("FAIL release_af[edge %0d] got=%b exp=1", e, bus.almost_full); end
    end
  endtask

  task automatic test_wrap();
    // rbin = 17 -> gray 11001
    bus.rd_gray = 5'b11001;
    drive(1'b0, 5'd31);
    for (int i = 0; i < 3; i++) tick();
    n_checks++; if (bus.level !== 5'd14) begin n_fail++; $display("FAIL wrap_pre_level got=%0d exp=14", bus.level); end
    n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL wrap_pre_full got=%b exp=0", bus.full); end
    drive(1'b1, 5'd31);
    tick();
    n_checks++; if (bus.level !== 5'd15) begin n_fail++; $display("FAIL wrap_level got=%0d exp=15", bus.level); end
    n_checks++; if (bus.wr_gray !== 5'd0) begin n_fail++; $display("FAIL wrap_wr_gray got=%b exp=00000", bus.wr_gray); end
    n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL wrap_full got=%b exp=0", bus.full); end
    // One more write after the roll fills the FIFO: bin 1 vs rbin 17.
    drive(1'b1, 5'd0);
    tick();
    n_checks++; if (bus.level !== 5'd16) begin n_fail++; $display("FAIL wrap_fill_level got=%0d exp=16", bus.level); end
    n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL wrap_fill_full got=%b exp=1", bus.full); end
    n_checks++; if (bus.wr_gray !== 5'b00001) begin n_fail++; $display("FAIL wrap_fill_wr_gray got=%b exp=00001", bus.wr_gray); end
  endtask

  task automatic test_reset_mid_fill();
    logic [PW-1:0] exp_gray [3];
    exp_gray[0] = 5'b00001;
    exp_gray[1] = 5'b00011;
    exp_gray[2] = 5'b00010;
    rst = 1'b1;
    bus.rd_gray = 5'd0;
    drive(1'b1, 5'd1);
    tick();
    n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL rstmid_full got=%b exp=0", bus.full); end
    n_checks++; if (bus.level !== 5'd0) begin n_fail++; $display("FAIL rstmid_level got=%0d exp=0", bus.level); end
    n_checks++; if (bus.wr_gray !== 5'd0) begin n_fail++; $display("FAIL rstmid_wr_gray got=%b exp=0", bus.wr_gray); end
    n_checks++; if (bus.almost_full !== 1'b0) begin n_fail++; $display("FAIL rstmid_af got=%b exp=0", bus.almost_full); end
    n_checks++; if (dut.u_sync.q_o !== 5'd0) begin n_fail++; $display("FAIL rstmid_rq2 got=%b exp=0", dut.u_sync.q_o); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(i));
      tick();
      n_checks++; if (bus.level !== 5'(i + 1)) begin n_fail++; $display("FAIL resume_level[%0d] got=%0d exp=%0d", i, bus.level, i + 1); end
      n_checks++; if (bus.wr_gray !== exp_gray[i]) begin n_fail++; $display("FAIL resume_wr_gray[%0d] got=%b exp=%b", i, bus.wr_gray, exp_gray[i]); end
    end
  endtask

  task automatic test_simultaneous();
    // level 3, reader moves to 2 (gray 00011); write lands on the edge rq2 is used.
    drive(1'b0, 5'd3);
    bus.rd_gray = 5'b00011;
    for (int e = 1; e <= 2; e++) begin
      tick();
      n_checks++; if (bus.level !== 5'd3) begin n_fail++; $display("FAIL simul_hold_level[edge %0d] got=%0d exp=3", e, bus.level); end
    end
    drive(1'b1, 5'd3);
    tick();
    n_checks++; if (bus.level !== 5'd2) begin n_fail++; $display("FAIL simul_level got=%0d exp=2", bus.level); end
    n_checks++; if (bus.wr_gray !== 5'b00110) begin n_fail++; $display("FAIL simul_wr_gray got=%b exp=00110", bus.wr_gray); end
    drive(1'b0, 5'd4);
  endtask

  // full must always agree with level == depth.
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if (bus.full !== (bus.level == 5'd16)) begin
        n_fail++;
        $display("FAIL full_vs_level got full=%b level=%0d", bus.full, bus.level);
      end
    end
  end

  initial begin
    bus.inc      = 1'b0;
    bus.ptr      = '0;
    bus.next_ptr = '0;
    bus.rd_gray  = '0;
    #1;
    test_reset();
    test_fill();
    test_blocked();
    test_release();
    test_wrap();
    test_reset_mid_fill();
    test_simultaneous();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_wr_full_gen
